pong_match_ctrl: RTL and testbench

//  Match-level sequencer for the Pong engine: runs attract/serve/play/point/game-over flow,

---
 rtl/pong_pkg.sv | 16 +
 rtl/edge_rise.sv | 13 +
 rtl/pong_match_ctrl.sv | 134 +++++++++++++
 tb/tb_pong_match_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: match state encodings, winner codes and serve-direction constants shared across the Pong engine.
package pong_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4,
    S_PAUSED    = 3'd5
  } state_t;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: registered-previous-level rising-edge detector for a debounced button.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer (attract/serve/play/point/game-over), scores and ball gating.
// Define PONG_PAUSE_EN to add the PAUSED state driven by pause_btn.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               out_left,
  input  logic               out_right,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [1:0]         winner,
  output logic [2:0]         state_o
);
  localparam int CW = $clog2((SERVE_FRAMES > OVER_FRAMES ? SERVE_FRAMES : OVER_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_FRAMES - 1);
  state_t st;
  logic [CW-1:0] frame_cnt;
  logic start_rise;
  edge_rise u_start (.clk(clk), .rst(rst), .level(start_btn), .rise(start_rise));
`ifdef PONG_PAUSE_EN
  state_t saved;
  logic pause_rise;
  edge_rise u_pause (.clk(clk), .rst(rst), .level(pause_btn), .rise(pause_rise));
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif
  assign state_o = st;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= SERVE_RIGHT;
      score_p1   <= '0;
      score_p2   <= '0;
      winner     <= WINNER_NONE;
      frame_cnt  <= '0;
`ifdef PONG_PAUSE_EN
      saved      <= S_IDLE;
`endif
    end else begin
      ball_reset <= 1'b0;
      if (start_rise && (st == S_IDLE || st == S_GAME_OVER)) begin
        score_p1   <= '0;
        score_p2   <= '0;
        winner     <= WINNER_NONE;
        frame_cnt  <= '0;
        ball_reset <= 1'b1;
        st         <= S_SERVE;
      end else begin
        case (st)
          S_SERVE:
`ifdef PONG_PAUSE_EN
            if (pause_rise) begin
              saved <= st;
              st    <= S_PAUSED;
            end else
`endif
            if (frame_tick) begin
              if (frame_cnt == SERVE_LAST) begin
                frame_cnt <= '0;
                ball_run  <= 1'b1;
                st        <= S_PLAY;
              end else frame_cnt <= frame_cnt + 1'b1;
            end
          S_PLAY:
`ifdef PONG_PAUSE_EN
            if (pause_rise) begin
              saved    <= st;
              ball_run <= 1'b0;
              st       <= S_PAUSED;
            end else
`endif
            if (out_left || out_right) begin
              ball_run <= 1'b0;
              st       <= S_POINT;
              // simultaneous exits cancel: nobody scores, serve side kept
              if (out_left && !out_right) begin
                score_p2  <= score_p2 + 1'b1;
                serve_dir <= SERVE_LEFT;
              end else if (out_right && !out_left) begin
                score_p1  <= score_p1 + 1'b1;
                serve_dir <= SERVE_RIGHT;
              end
            end
          S_POINT:
            if (score_p1 == WIN) begin
              winner <= WINNER_P1;
              st     <= S_GAME_OVER;
            end else if (score_p2 == WIN) begin
              winner <= WINNER_P2;
              st     <= S_GAME_OVER;
            end else begin
              ball_reset <= 1'b1;
              st         <= S_SERVE;
            end
          S_GAME_OVER:
            if (frame_tick) begin
              if (frame_cnt == OVER_LAST) begin
                frame_cnt <= '0;
                st        <= S_IDLE;
              end else frame_cnt <= frame_cnt + 1'b1;
            end
`ifdef PONG_PAUSE_EN
          S_PAUSED:
            if (start_rise) begin
              frame_cnt <= '0;
              st        <= S_IDLE;
            end else if (pause_rise) begin
              ball_run <= (saved == S_PLAY);
              st       <= saved;
            end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: scoreboard bench for the default (no pause) match controller build.
module tb_pong_match_ctrl;
  import pong_pkg::*;
  localparam int ST = 0, RUN = 1, BR = 2, DIR = 3, P1 = 4, P2 = 5, WN = 6;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic out_left = 1'b0, out_right = 1'b0;
  logic ball_run, ball_reset, serve_dir;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;
  logic [2:0] state_o;
  int total = 0, bad = 0;
  typedef struct {string tag; int sig; int val;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  pong_match_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start_btn(start_btn),
    .pause_btn(pause_btn), .out_left(out_left), .out_right(out_right),
    .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .score_p1(score_p1), .score_p2(score_p2), .winner(winner), .state_o(state_o)
  );
  function automatic logic [31:0] obs(int s);
    return s == ST ? 32'(state_o) : s == RUN ? 32'(ball_run) : s == BR ? 32'(ball_reset) :
           s == DIR ? 32'(serve_dir) : s == P1 ? 32'(score_p1) : s == P2 ? 32'(score_p2) :
           32'(winner);
  endfunction
  task automatic check(string tag, logic [31:0] got, int want);
    total++;
    if (got !== 32'(want)) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic push(string tag, int sig, int val);
    sb.push_back('{tag, sig, val});
  endtask
  task automatic drain;
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic tick;
    frame_tick = 1'b1;
    cyc;
    frame_tick = 1'b0;
    cyc;
  endtask
  task automatic play_in;
    push("to_play_st", ST, 2);
    push("to_play_run", RUN, 1);
    repeat (60) tick;
    drain;
  endtask
  task automatic push_reset(string pfx);
    push({pfx, "_st"}, ST, 0);
    push({pfx, "_run"}, RUN, 0);
    push({pfx, "_br"}, BR, 0);
    push({pfx, "_dir"}, DIR, 1);
    push({pfx, "_p1"}, P1, 0);
    push({pfx, "_p2"}, P2, 0);
    push({pfx, "_win"}, WN, 0);
  endtask
  initial begin
    int n;
    repeat (2) cyc;
    push_reset("rst");
    rst = 1'b0;
    cyc;
    drain;
    // start edge together with a frame tick: that tick must not be counted
    push("go_st", ST, 1);
    push("go_br", BR, 1);
    start_btn = 1'b1;
    frame_tick = 1'b1;
    cyc;
    frame_tick = 1'b0;
    drain;
    push("br_once", BR, 0);
    push("srv_ign_st", ST, 1);
    push("srv_ign_p2", P2, 0);
    out_left = 1'b1;
    cyc;
    out_left = 1'b0;
    drain;
    push("srv59_st", ST, 1);
    push("srv59_run", RUN, 0);
    repeat (59) tick;
    drain;
    push("play_st", ST, 2);
    push("play_run", RUN, 1);
    tick;
    drain;
    start_btn = 1'b0;
    push("pt_st", ST, 3);
    push("pt_p1", P1, 1);
    push("pt_dir", DIR, 1);
    push("pt_run", RUN, 0);
    out_right = 1'b1;
    cyc;
    out_right = 1'b0;
    drain;
    push("pt_srv", ST, 1);
    push("pt_br", BR, 1);
    cyc;
    drain;
    for (int k = 1; k <= 6; k++) begin
      play_in;
      push("l_st", ST, 3);
      push("l_p2", P2, k);
      push("l_dir", DIR, 0);
      out_left = 1'b1;
      cyc;
      out_left = 1'b0;
      drain;
      push("l_srv", ST, 1);
      push("l_br", BR, 1);
      cyc;
      drain;
    end
    play_in;
    push("both_st", ST, 3);
    push("both_p1", P1, 1);
    push("both_p2", P2, 6);
    push("both_dir", DIR, 0);
    out_left = 1'b1;
    out_right = 1'b1;
    cyc;
    out_left = 1'b0;
    out_right = 1'b0;
    drain;
    push("both_srv", ST, 1);
    push("both_win", WN, 0);
    push("both_br", BR, 1);
    cyc;
    drain;
    play_in;
    push("fin_st", ST, 3);
    push("fin_p2", P2, 7);
    out_left = 1'b1;
    cyc;
    out_left = 1'b0;
    drain;
    push("go_over_st", ST, 4);
    push("go_over_win", WN, 2);
    push("go_over_run", RUN, 0);
    push("go_over_br", BR, 0);
    cyc;
    drain;
    push("over179_st", ST, 4);
    repeat (179) tick;
    drain;
    push("idle_st", ST, 0);
    push("idle_p2", P2, 7);
    push("idle_p1", P1, 1);
    tick;
    drain;
    push("re_st", ST, 1);
    push("re_p1", P1, 0);
    push("re_p2", P2, 0);
    push("re_win", WN, 0);
    push("re_br", BR, 1);
    start_btn = 1'b1;
    cyc;
    start_btn = 1'b0;
    drain;
    play_in;
    #2;
    rst = 1'b1;
    #1;
    push_reset("arst");
    drain;
    cyc;
    rst = 1'b0;
    cyc;
    // held start in IDLE launches exactly one match
    push("hold_st", ST, 1);
    push("hold_br", BR, 1);
    start_btn = 1'b1;
    cyc;
    drain;
    n = 0;
    repeat (999) begin
      cyc;
      n += int'(ball_reset);
    end
    push("hold_st_end", ST, 1);
    drain;
    check("hold_br_cnt", 32'(n), 0);
    start_btn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
